// File: rtl/uart_rx_multi.sv
// Parametrised UART receiver: frame decode with parity/stop checking, sticky error
// flags, a first-word-fall-through output FIFO and a running byte checksum.
module uart_rx_multi #(
    parameter int CLOCKS_PER_BIT = 3,
    parameter int DATA_BITS      = 8,
    parameter int PARITY         = 0,
    parameter int STOP_BITS      = 1,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_serial,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    input  logic                 i_clear,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_overrun,
    output logic [31:0]          o_sum,
    output logic                 o_busy
);

    localparam int CNT_W  = $clog2(CLOCKS_PER_BIT);
    localparam int IDX_W  = $clog2(DATA_BITS);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(CLOCKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST  = 1'(STOP_BITS - 1);
    localparam logic             ODD_PARITY = (PARITY == 2);
    localparam logic [PTR_W-1:0] PTR_FULL   = PTR_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, sync2_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 stop_err_q, stop_err_d;
    logic                 par_err_q, par_err_d;
    logic                 busy_q, busy_d;
    logic [PTR_W-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic                 frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d;
    logic                 overrun_q, overrun_d;
    logic [31:0]          sum_q, sum_d;

    logic line;
    logic frame_done;
    logic frame_bad_stop;
    logic frame_good;
    logic full;
    logic push;
    logic pop;

    assign line = sync2_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        shift_d        = shift_q;
        stop_idx_d     = stop_idx_q;
        stop_err_d     = stop_err_q;
        par_err_d      = par_err_q;
        frame_done     = 1'b0;
        frame_bad_stop = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!line) begin
                    state_d    = S_START;
                    cnt_d      = '0;
                    idx_d      = '0;
                    stop_idx_d = 1'b0;
                    stop_err_d = 1'b0;
                    par_err_d  = 1'b0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = line ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    // LSB arrives first, so after DATA_BITS right-shifts it sits at bit 0
                    shift_d = {line, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    par_err_d = ((^shift_q) ^ line) != ODD_PARITY;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (stop_idx_q == STOP_LAST) begin
                        frame_done     = 1'b1;
                        frame_bad_stop = stop_err_q | !line;
                        state_d        = line ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        stop_idx_d = 1'b1;
                        stop_err_d = stop_err_q | !line;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_HIGH: begin
                if (line) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_valid = (wr_q != rd_q);
    assign full    = ((wr_q - rd_q) == PTR_FULL);
    assign pop     = o_valid & i_ready;

    // A simultaneous pop frees the slot, so a full FIFO still accepts the push
    always_comb begin
        frame_good   = frame_done & !par_err_q & !frame_bad_stop;
        push         = frame_good & (!full | pop);
        wr_d         = push ? wr_q + PTR_W'(1) : wr_q;
        rd_d         = pop ? rd_q + PTR_W'(1) : rd_q;
        busy_d       = (state_d != S_IDLE);
        frame_err_d  = (i_clear ? 1'b0 : frame_err_q) | (frame_done & frame_bad_stop);
        parity_err_d = (i_clear ? 1'b0 : parity_err_q) | (frame_done & par_err_q);
        overrun_d    = (i_clear ? 1'b0 : overrun_q) | (frame_good & full & !pop);
        sum_d        = (i_clear ? 32'd0 : sum_q) + (push ? 32'(shift_q) : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            stop_idx_q   <= 1'b0;
            stop_err_q   <= 1'b0;
            par_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            wr_q         <= '0;
            rd_q         <= '0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            sum_q        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            sync1_q      <= i_serial;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            stop_idx_q   <= stop_idx_d;
            stop_err_q   <= stop_err_d;
            par_err_q    <= par_err_d;
            busy_q       <= busy_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            sum_q        <= sum_d;
            if (push) begin
                mem_q[wr_q[ADDR_W-1:0]] <= shift_q;
            end
        end
    end

    assign o_data       = mem_q[rd_q[ADDR_W-1:0]];
    assign o_frame_err  = frame_err_q;
    assign o_parity_err = parity_err_q;
    assign o_overrun    = overrun_q;
    assign o_sum        = sum_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_multi.sv
// Bench for uart_rx_multi: DUT A is 8N1 CPB=3 depth 4, DUT B is 8E2 CPB=4 depth 2.
// A frame-level model (byte queues, sum, flags) predicts every checked output.
module tb_uart_rx_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, ser_a, ser_b, rdy_a, rdy_b, clr_a, clr_b;
    logic [7:0]  data_a, data_b;
    logic        valid_a, valid_b, ferr_a, ferr_b, perr_a, perr_b;
    logic        ovr_a, ovr_b, busy_a, busy_b;
    logic [31:0] sum_a, sum_b;

    uart_rx_multi #(
        .CLOCKS_PER_BIT(3), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst(rst_a), .i_serial(ser_a), .o_data(data_a), .o_valid(valid_a),
        .i_ready(rdy_a), .i_clear(clr_a), .o_frame_err(ferr_a), .o_parity_err(perr_a),
        .o_overrun(ovr_a), .o_sum(sum_a), .o_busy(busy_a)
    );

    uart_rx_multi #(
        .CLOCKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(2)
    ) dut_b (
        .clk(clk), .rst(rst_b), .i_serial(ser_b), .o_data(data_b), .o_valid(valid_b),
        .i_ready(rdy_b), .i_clear(clr_b), .o_frame_err(ferr_b), .o_parity_err(perr_b),
        .o_overrun(ovr_b), .o_sum(sum_b), .o_busy(busy_b)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [31:0] m_sum  [2];
    logic        m_ferr [2];
    logic        m_perr [2];
    logic        m_ovr  [2];

    function automatic int cpbOf(input int w);
        return (w == 0) ? 3 : 4;
    endfunction

    function automatic int depthOf(input int w);
        return (w == 0) ? 4 : 2;
    endfunction

    function automatic int countOf(input int w);
        return (w == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void modelClear(input int w);
        m_sum[w]  = 32'd0;
        m_ferr[w] = 1'b0;
        m_perr[w] = 1'b0;
        m_ovr[w]  = 1'b0;
    endfunction

    function automatic void modelReset(input int w);
        modelClear(w);
        if (w == 0) q0.delete(); else q1.delete();
    endfunction

    function automatic void modelPop(input int w);
        if (w == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    endfunction

    // kind: 0 good, 1 last stop low, 2 parity flipped, 3 first of two stops low
    function automatic void modelFrame(input int w, input logic [7:0] d, input int kind);
        if (kind == 0) begin
            if (countOf(w) < depthOf(w)) begin
                if (w == 0) q0.push_back(d); else q1.push_back(d);
                m_sum[w] = m_sum[w] + {24'd0, d};
            end else begin
                m_ovr[w] = 1'b1;
            end
        end else if (kind == 2) begin
            m_perr[w] = 1'b1;
        end else begin
            m_ferr[w] = 1'b1;
        end
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input int w);
        string pre;
        pre = (w == 0) ? "a" : "b";
        checkVal({pre, "_valid"}, 32'(w == 0 ? valid_a : valid_b), 32'(countOf(w) > 0));
        if (countOf(w) > 0) begin
            checkVal({pre, "_data"}, 32'(w == 0 ? data_a : data_b),
                     32'(w == 0 ? q0[0] : q1[0]));
        end
        checkVal({pre, "_sum"}, (w == 0) ? sum_a : sum_b, m_sum[w]);
        checkVal({pre, "_frame_err"}, 32'(w == 0 ? ferr_a : ferr_b), 32'(m_ferr[w]));
        checkVal({pre, "_parity_err"}, 32'(w == 0 ? perr_a : perr_b), 32'(m_perr[w]));
        checkVal({pre, "_overrun"}, 32'(w == 0 ? ovr_a : ovr_b), 32'(m_ovr[w]));
    endtask

    task automatic setSer(input int w, input logic v);
        if (w == 0) ser_a = v; else ser_b = v;
    endtask

    task automatic setRdy(input int w, input logic v);
        if (w == 0) rdy_a = v; else rdy_b = v;
    endtask

    task automatic setClr(input int w, input logic v);
        if (w == 0) clr_a = v; else clr_b = v;
    endtask

    // Entered and left on a negedge; each bit is held for exactly one bit period
    task automatic sendFrame(input int w, input logic [7:0] d, input int kind);
        logic bits[$];
        int   nstop;
        nstop = (w == 0) ? 1 : 2;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (w == 1) bits.push_back((^d) ^ (kind == 2));
        for (int s = 0; s < nstop; s++) begin
            if (kind == 1 && s == nstop - 1) bits.push_back(1'b0);
            else if (kind == 3 && s == 0) bits.push_back(1'b0);
            else bits.push_back(1'b1);
        end
        foreach (bits[i]) begin
            setSer(w, bits[i]);
            repeat (cpbOf(w)) @(negedge clk);
        end
        setSer(w, 1'b1);
    endtask

    task automatic applyStimulus(input int w, input logic [7:0] d, input int kind);
        sendFrame(w, d, kind);
        modelFrame(w, d, kind);
        repeat (4) @(negedge clk);
    endtask

    task automatic drainCheck(input int w);
        while (countOf(w) > 0) begin
            checkOutput(w);
            setRdy(w, 1'b1);
            @(negedge clk);
            setRdy(w, 1'b0);
            modelPop(w);
        end
        checkOutput(w);
    endtask

    task automatic pulseClear(input int w);
        setClr(w, 1'b1);
        @(negedge clk);
        setClr(w, 1'b0);
        modelClear(w);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] d;
        int         r, kind;

        ser_a = 1'b1; ser_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
        modelReset(0);
        modelReset(1);
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        $display("[TB] reset state");
        checkOutput(0);
        checkOutput(1);
        checkVal("a_data_rst", 32'(data_a), 32'd0);
        checkVal("b_data_rst", 32'(data_b), 32'd0);
        checkVal("a_busy_rst", 32'(busy_a), 32'd0);
        checkVal("b_busy_rst", 32'(busy_b), 32'd0);

        $display("[TB] single 0x55 frame with exact push latency");
        sendFrame(0, 8'h55, 0);
        @(negedge clk);
        checkVal("a_valid_before_push", 32'(valid_a), 32'd0);
        @(negedge clk);
        modelFrame(0, 8'h55, 0);
        checkVal("a_valid_after_push", 32'(valid_a), 32'd1);
        checkOutput(0);
        drainCheck(0);

        $display("[TB] three 0xFF frames popped as they arrive");
        pulseClear(0);
        checkOutput(0);
        rdy_a = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sendFrame(0, 8'hFF, 0);
            repeat (2) @(negedge clk);
            checkVal("a_ff_valid", 32'(valid_a), 32'd1);
            checkVal("a_ff_data", 32'(data_a), 32'hFF);
            m_sum[0] = m_sum[0] + 32'hFF;
            @(negedge clk);
            checkVal("a_ff_popped", 32'(valid_a), 32'd0);
        end
        rdy_a = 1'b0;
        checkVal("a_sum_2fd", sum_a, 32'h2FD);
        checkOutput(0);

        $display("[TB] even parity: bad then good");
        applyStimulus(1, 8'hA5, 2);
        checkOutput(1);
        applyStimulus(1, 8'h3C, 0);
        drainCheck(1);

        $display("[TB] line held low for 20 bit times");
        setSer(0, 1'b0);
        repeat (60) @(negedge clk);
        m_ferr[0] = 1'b1;
        checkVal("a_busy_held_low", 32'(busy_a), 32'd1);
        checkOutput(0);
        setSer(0, 1'b1);
        repeat (4) @(negedge clk);
        checkVal("a_busy_released", 32'(busy_a), 32'd0);
        applyStimulus(0, 8'h41, 0);
        drainCheck(0);

        $display("[TB] glitch and overrun on depth-2 receiver");
        setSer(1, 1'b0);
        @(negedge clk);
        setSer(1, 1'b1);
        repeat (10) @(negedge clk);
        checkVal("b_busy_glitch", 32'(busy_b), 32'd0);
        checkOutput(1);
        pulseClear(1);
        for (int k = 0; k < 3; k++) applyStimulus(1, 8'($urandom), 0);
        checkOutput(1);
        drainCheck(1);

        $display("[TB] randomized frames");
        pulseClear(0);
        pulseClear(1);
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 10; k++) begin
                d = 8'($urandom);
                r = $urandom_range(0, 9);
                if (w == 0) kind = (r < 2) ? 1 : 0;
                else kind = (r < 3) ? r + 1 : 0;
                applyStimulus(w, d, kind);
                checkOutput(w);
                if ($urandom_range(0, 2) == 0) drainCheck(w);
            end
            drainCheck(w);
        end

        $display("[TB] reset mid-frame");
        pulseClear(0);
        applyStimulus(0, 8'h33, 0);
        checkOutput(0);
        setSer(0, 1'b0);
        repeat (12) @(negedge clk);
        rst_a = 1'b1;
        setSer(0, 1'b1);
        @(negedge clk);
        rst_a = 1'b0;
        modelReset(0);
        checkOutput(0);
        checkVal("a_busy_after_rst", 32'(busy_a), 32'd0);
        checkVal("a_data_after_rst", 32'(data_a), 32'd0);
        applyStimulus(0, 8'h0F, 0);
        drainCheck(0);
        applyStimulus(0, 8'hC3, 1);
        checkOutput(0);
        pulseClear(0);
        checkOutput(0);

        $display("[TB] push and pop together on a full FIFO");
        for (int k = 0; k < 4; k++) applyStimulus(0, 8'($urandom), 0);
        checkOutput(0);
        d = 8'($urandom);
        sendFrame(0, d, 0);
        @(negedge clk);
        rdy_a = 1'b1;
        @(negedge clk);
        rdy_a = 1'b0;
        modelPop(0);
        modelFrame(0, d, 0);
        repeat (2) @(negedge clk);
        checkOutput(0);
        drainCheck(0);

        $display("[TB] clear coinciding with a push");
        applyStimulus(0, 8'h5A, 1);
        checkOutput(0);
        d = 8'($urandom);
        sendFrame(0, d, 0);
        @(negedge clk);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        modelClear(0);
        modelFrame(0, d, 0);
        repeat (2) @(negedge clk);
        checkOutput(0);
        drainCheck(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
